// File: rtl/bip_pkg.sv
// Shared definitions for the BIP fetch/control slice: widths, opcodes,
// datapath select encodings, FSM states and the decoded control word.
package bip_pkg;

  localparam int PC_W_DEF    = 11;
  localparam int INSTR_W_DEF = 16;
  localparam int CNT_W_DEF   = 16;
  localparam int OPC_W       = 5;

  localparam logic [OPC_W-1:0] OP_HALT = 5'b00000;
  localparam logic [OPC_W-1:0] OP_STO  = 5'b00001;
  localparam logic [OPC_W-1:0] OP_LD   = 5'b00010;
  localparam logic [OPC_W-1:0] OP_LDI  = 5'b00011;
  localparam logic [OPC_W-1:0] OP_ADD  = 5'b00100;
  localparam logic [OPC_W-1:0] OP_ADDI = 5'b00101;
  localparam logic [OPC_W-1:0] OP_SUB  = 5'b00110;
  localparam logic [OPC_W-1:0] OP_SUBI = 5'b00111;

  localparam logic [1:0] SEL_RAM = 2'b00;
  localparam logic [1:0] SEL_IMM = 2'b01;
  localparam logic [1:0] SEL_ALU = 2'b10;

  localparam logic ALU_ADD = 1'b0;
  localparam logic ALU_SUB = 1'b1;

  typedef enum logic [1:0] {
    ST_ISSUE   = 2'd0,
    ST_DECODE  = 2'd1,
    ST_EXECUTE = 2'd2,
    ST_HALTED  = 2'd3
  } state_t;

  // Bit order (MSB first) is the order the strobes leave the fetch unit.
  typedef struct packed {
    logic       wr_acc;
    logic [1:0] sel_a;
    logic       sel_b;
    logic       alu_op;
    logic       rd_ram;
    logic       wr_ram;
    logic       illegal;
  } ctrl_t;

  localparam ctrl_t CTRL_NONE = '0;

endpackage

// File: rtl/bip_fetch_control_if.sv
// Program-memory port plus datapath control strobes of the BIP fetch unit.
// master = fetch/control unit, slave = program memory and datapath side.
interface bip_fetch_control_if #(
  parameter int PC_W    = bip_pkg::PC_W_DEF,
  parameter int INSTR_W = bip_pkg::INSTR_W_DEF
);
  logic [PC_W-1:0]    prog_addr;
  logic [INSTR_W-1:0] prog_data;
  logic [PC_W-1:0]    operand;
  logic               wr_acc;
  logic [1:0]         sel_a;
  logic               sel_b;
  logic               alu_op;
  logic               rd_ram;
  logic               wr_ram;

  modport master (
    output prog_addr, operand, wr_acc, sel_a, sel_b, alu_op, rd_ram, wr_ram,
    input  prog_data
  );

  modport slave (
    input  prog_addr, operand, wr_acc, sel_a, sel_b, alu_op, rd_ram, wr_ram,
    output prog_data
  );
endinterface

// File: rtl/bip_decoder.sv
// Purely combinational opcode decoder producing the BIP datapath control word.
module bip_decoder
  import bip_pkg::*;
(
  input  logic [OPC_W-1:0] opcode,
  output ctrl_t            ctrl
);

  always_comb begin
    ctrl = CTRL_NONE;
    case (opcode)
      OP_HALT: ctrl = CTRL_NONE;
      OP_STO:  ctrl.wr_ram = 1'b1;
      OP_LD: begin
        ctrl.rd_ram = 1'b1;
        ctrl.wr_acc = 1'b1;
        ctrl.sel_a  = SEL_RAM;
      end
      OP_LDI: begin
        ctrl.wr_acc = 1'b1;
        ctrl.sel_a  = SEL_IMM;
      end
      OP_ADD: begin
        ctrl.rd_ram = 1'b1;
        ctrl.wr_acc = 1'b1;
        ctrl.sel_a  = SEL_ALU;
        ctrl.sel_b  = 1'b0;
        ctrl.alu_op = ALU_ADD;
      end
      OP_ADDI: begin
        ctrl.wr_acc = 1'b1;
        ctrl.sel_a  = SEL_ALU;
        ctrl.sel_b  = 1'b1;
        ctrl.alu_op = ALU_ADD;
      end
      OP_SUB: begin
        ctrl.rd_ram = 1'b1;
        ctrl.wr_acc = 1'b1;
        ctrl.sel_a  = SEL_ALU;
        ctrl.sel_b  = 1'b0;
        ctrl.alu_op = ALU_SUB;
      end
      OP_SUBI: begin
        ctrl.wr_acc = 1'b1;
        ctrl.sel_a  = SEL_ALU;
        ctrl.sel_b  = 1'b1;
        ctrl.alu_op = ALU_SUB;
      end
      // Undefined opcodes behave as a NOP that flags itself.
      default: ctrl.illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/bip_fetch_control.sv
// BIP instruction fetch and control: owns PC/IR, runs the 3-cycle
// ISSUE/DECODE/EXECUTE sequence and gates decoded strobes into EXECUTE.
module bip_fetch_control
  import bip_pkg::*;
#(
  parameter int PC_W    = PC_W_DEF,
  parameter int INSTR_W = INSTR_W_DEF,
  parameter int CNT_W   = CNT_W_DEF
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                enable,
  bip_fetch_control_if.master bus,
  output logic                illegal,
  output logic                halted,
  output logic [CNT_W-1:0]    instr_count
);

  localparam int CTRL_W = $bits(ctrl_t);

  state_t             state_reg, state_next;
  logic [PC_W-1:0]    pc_reg, pc_next;
  logic [INSTR_W-1:0] ir_reg, ir_next;
  logic [CNT_W-1:0]   cnt_reg, cnt_next;
  logic               exec_en;

  ctrl_t              ctrl_dec;
  ctrl_t              ctrl_out;
  logic [CTRL_W-1:0]  dec_bits;
  logic [CTRL_W-1:0]  out_bits;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg <= ST_ISSUE;
      pc_reg    <= '0;
      ir_reg    <= '0;
      cnt_reg   <= '0;
    end else begin
      state_reg <= state_next;
      pc_reg    <= pc_next;
      ir_reg    <= ir_next;
      cnt_reg   <= cnt_next;
    end
  end

  // Everything holds while enable is low; a stalled EXECUTE simply re-runs
  // on the first enabled cycle, which is also the only one that retires it.
  always_comb begin
    state_next = state_reg;
    pc_next    = pc_reg;
    ir_next    = ir_reg;
    cnt_next   = cnt_reg;
    exec_en    = 1'b0;
    case (state_reg)
      ST_ISSUE: begin
        if (enable) state_next = ST_DECODE;
      end
      ST_DECODE: begin
        if (enable) begin
          ir_next    = bus.prog_data;
          pc_next    = pc_reg + PC_W'(1);
          state_next = ST_EXECUTE;
        end
      end
      ST_EXECUTE: begin
        if (enable) begin
          exec_en = 1'b1;
          if (cnt_reg != {CNT_W{1'b1}}) cnt_next = cnt_reg + CNT_W'(1);
          state_next = (ir_reg[INSTR_W-1 -: OPC_W] == OP_HALT) ? ST_HALTED : ST_ISSUE;
        end
      end
      ST_HALTED: state_next = ST_HALTED;
      default:   state_next = ST_ISSUE;
    endcase
  end

  bip_decoder u_decoder (
    .opcode (ir_reg[INSTR_W-1 -: OPC_W]),
    .ctrl   (ctrl_dec)
  );

  assign dec_bits = ctrl_dec;

  generate
    for (genvar gi = 0; gi < CTRL_W; gi++) begin : g_gate
      assign out_bits[gi] = dec_bits[gi] & exec_en;
    end
  endgenerate

  assign ctrl_out = ctrl_t'(out_bits);

  assign bus.prog_addr = pc_reg;
  assign bus.operand   = ir_reg[PC_W-1:0];
  assign bus.wr_acc    = ctrl_out.wr_acc;
  assign bus.sel_a     = ctrl_out.sel_a;
  assign bus.sel_b     = ctrl_out.sel_b;
  assign bus.alu_op    = ctrl_out.alu_op;
  assign bus.rd_ram    = ctrl_out.rd_ram;
  assign bus.wr_ram    = ctrl_out.wr_ram;
  assign illegal       = ctrl_out.illegal;
  assign halted        = (state_reg == ST_HALTED);
  assign instr_count   = cnt_reg;

endmodule

// File: tb/tb_bip_fetch_control.sv
// Directed bench for bip_fetch_control with a synchronous 2048x16 program
// memory model that returns 16'hFFFF while reset is asserted.
module tb_bip_fetch_control;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        enable = 1'b0;
  logic        illegal;
  logic        halted;
  logic [15:0] instr_count;
  logic [7:0]  strb;
  logic [15:0] mem [0:2047];

  int n_tests = 0;
  int n_fail  = 0;

  bip_fetch_control_if #(.PC_W(11), .INSTR_W(16)) bus ();

  bip_fetch_control #(.PC_W(11), .INSTR_W(16), .CNT_W(16)) dut (
    .clk         (clk),
    .rst         (rst),
    .enable      (enable),
    .bus         (bus),
    .illegal     (illegal),
    .halted      (halted),
    .instr_count (instr_count)
  );

  always #5 clk = ~clk;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) bus.prog_data <= 16'hFFFF;
    else      bus.prog_data <= mem[bus.prog_addr];
  end

  assign strb = {bus.wr_acc, bus.sel_a, bus.sel_b, bus.alu_op, bus.rd_ram, bus.wr_ram, illegal};

  task automatic clear_mem(input logic [15:0] fill);
    for (int i = 0; i < 2048; i++) mem[i] = fill;
  endtask

  task automatic load_prog();
    clear_mem(16'h0000);
    mem[0] = 16'h1804; // LDI 4
    mem[1] = 16'h0801; // STO 1
    mem[2] = 16'h1802; // LDI 2
    mem[3] = 16'h1001; // LD 1
    mem[4] = 16'h2001; // ADD 1
    mem[5] = 16'h0000; // HALT
  endtask

  // Returns on the negedge where reset is released: cycle 1 (ISSUE).
  task automatic do_reset();
    @(negedge clk);
    rst = 1'b0;
    enable = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    enable = 1'b1;
    repeat (2) @(negedge clk);
    n_tests++;
    if ({bus.prog_addr, bus.operand, strb, halted, instr_count} !== {11'd0, 11'd0, 8'h00, 1'b0, 16'd0}) begin
      n_fail++;
      $display("FAIL reset_state: addr=%0d operand=%0d strb=%h halted=%b cnt=%0d, required all 0",
               bus.prog_addr, bus.operand, strb, halted, instr_count);
    end
  endtask

  task automatic test_program();
    logic [7:0]  exp_tab [6] = '{8'hA0, 8'h02, 8'hA0, 8'h84, 8'hC4, 8'h00};
    logic [10:0] opd_tab [6] = '{11'd4, 11'd1, 11'd2, 11'd1, 11'd1, 11'd0};
    logic [10:0] e_addr;
    logic [7:0]  e_strb;
    logic        e_halt;
    logic [15:0] e_cnt;
    int i, p;
    load_prog();
    do_reset();
    for (int c = 1; c <= 21; c++) begin
      if (c > 1) @(negedge clk);
      i = (c - 1) / 3;
      p = (c - 1) % 3;
      e_addr = (c >= 19) ? 11'd6 : ((p == 2) ? 11'(i + 1) : 11'(i));
      e_strb = (p == 2 && c <= 18) ? exp_tab[i] : 8'h00;
      e_halt = (c >= 19);
      e_cnt  = (c >= 19) ? 16'd6 : 16'(i);
      n_tests++;
      if ({bus.prog_addr, strb, halted, instr_count} !== {e_addr, e_strb, e_halt, e_cnt}) begin
        n_fail++;
        $display("FAIL program_c%0d: addr=%0d strb=%h halted=%b cnt=%0d, required addr=%0d strb=%h halted=%b cnt=%0d",
                 c, bus.prog_addr, strb, halted, instr_count, e_addr, e_strb, e_halt, e_cnt);
      end
      if (p == 2 && c <= 18) begin
        $display("[TB] exec cycle=%0d instr=%0d strb=%h operand=%0d", c, i, strb, bus.operand);
        n_tests++;
        if (bus.operand !== opd_tab[i]) begin
          n_fail++;
          $display("FAIL program_operand_%0d: got %0d required %0d", i, bus.operand, opd_tab[i]);
        end
      end
    end
  endtask

  task automatic test_halt_persist();
    int bad = 0;
    for (int c = 0; c < 100; c++) begin
      @(negedge clk);
      enable = 1'($urandom_range(0, 1));
      #1;
      if ({bus.prog_addr, instr_count, strb, halted} !== {11'd6, 16'd6, 8'h00, 1'b1}) bad++;
    end
    enable = 1'b1;
    n_tests++;
    if (bad != 0) begin
      n_fail++;
      $display("FAIL halt_persist: %0d bad cycles, required 0 (last addr=%0d cnt=%0d strb=%h halted=%b)",
               bad, bus.prog_addr, instr_count, strb, halted);
    end
    $display("[TB] halt persistence checked over 100 cycles");
  endtask

  task automatic test_illegal();
    int pulses = 0;
    logic [7:0] e_strb;
    clear_mem(16'h0000);
    mem[0] = 16'hF800;
    mem[1] = 16'h0000;
    do_reset();
    for (int c = 1; c <= 8; c++) begin
      if (c > 1) @(negedge clk);
      if (illegal === 1'b1) pulses++;
      e_strb = (c == 3) ? 8'h01 : 8'h00;
      n_tests++;
      if (strb !== e_strb) begin
        n_fail++;
        $display("FAIL illegal_strb_c%0d: got %h required %h", c, strb, e_strb);
      end
    end
    n_tests++;
    if ({pulses[3:0], instr_count, halted} !== {4'd1, 16'd2, 1'b1}) begin
      n_fail++;
      $display("FAIL illegal_summary: pulses=%0d cnt=%0d halted=%b, required 1 2 1", pulses, instr_count, halted);
    end
    $display("[TB] illegal opcode pulses=%0d cnt=%0d", pulses, instr_count);
  endtask

  task automatic test_stall();
    int seen = 0;
    clear_mem(16'h0000);
    mem[0] = 16'h2803; // ADDI 3
    mem[1] = 16'h0000; // HALT
    do_reset();
    @(negedge clk);          // DECODE
    enable = 1'b0;
    repeat (3) begin
      @(negedge clk);
      #1;
      n_tests++;
      if ({bus.prog_addr, strb, instr_count} !== {11'd0, 8'h00, 16'd0}) begin
        n_fail++;
        $display("FAIL stall_decode: addr=%0d strb=%h cnt=%0d, required 0 00 0", bus.prog_addr, strb, instr_count);
      end
    end
    enable = 1'b1;
    @(negedge clk);          // EXECUTE
    enable = 1'b0;
    #1;
    repeat (5) begin
      n_tests++;
      if ({bus.prog_addr, bus.operand, strb, instr_count} !== {11'd1, 11'd3, 8'h00, 16'd0}) begin
        n_fail++;
        $display("FAIL stall_exec: addr=%0d operand=%0d strb=%h cnt=%0d, required 1 3 00 0",
                 bus.prog_addr, bus.operand, strb, instr_count);
      end
      @(negedge clk);
      #1;
    end
    enable = 1'b1;
    #1;
    if (strb != 8'h00) seen++;
    n_tests++;
    if ({strb, instr_count} !== {8'hD0, 16'd0}) begin
      n_fail++;
      $display("FAIL stall_release: strb=%h cnt=%0d, required d0 0", strb, instr_count);
    end
    @(negedge clk);
    #1;
    n_tests++;
    if ({bus.prog_addr, strb, instr_count} !== {11'd1, 8'h00, 16'd1}) begin
      n_fail++;
      $display("FAIL stall_after: addr=%0d strb=%h cnt=%0d, required 1 00 1", bus.prog_addr, strb, instr_count);
    end
    repeat (5) begin
      if (strb != 8'h00 && !(bus.operand == 11'd0 && strb == 8'h00)) seen++;
      @(negedge clk);
    end
    n_tests++;
    if ({seen[3:0], instr_count, halted} !== {4'd1, 16'd2, 1'b1}) begin
      n_fail++;
      $display("FAIL stall_summary: strobe_cycles=%0d cnt=%0d halted=%b, required 1 2 1", seen, instr_count, halted);
    end
    $display("[TB] stall ADDI 3 strobe_cycles=%0d cnt=%0d", seen, instr_count);
  endtask

  task automatic test_async_reset();
    load_prog();
    do_reset();
    repeat (7) @(negedge clk); // cycle 8: DECODE of instruction 2
    n_tests++;
    if ({instr_count, bus.operand} !== {16'd2, 11'd1}) begin
      n_fail++;
      $display("FAIL async_pre: cnt=%0d operand=%0d, required 2 1", instr_count, bus.operand);
    end
    #3;
    rst = 1'b0;
    #1;
    n_tests++;
    if ({bus.prog_addr, bus.operand, strb, halted, instr_count} !== {11'd0, 11'd0, 8'h00, 1'b0, 16'd0}) begin
      n_fail++;
      $display("FAIL async_reset: addr=%0d operand=%0d strb=%h halted=%b cnt=%0d, required all 0",
               bus.prog_addr, bus.operand, strb, halted, instr_count);
    end
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    n_tests++;
    if ({bus.prog_addr, bus.operand, strb} !== {11'd1, 11'd4, 8'hA0}) begin
      n_fail++;
      $display("FAIL async_restart: addr=%0d operand=%0d strb=%h, required 1 4 a0", bus.prog_addr, bus.operand, strb);
    end
    $display("[TB] async reset restart addr=%0d operand=%0d", bus.prog_addr, bus.operand);
  endtask

  task automatic test_wrap();
    int guard = 0;
    clear_mem(16'h1800); // LDI 0 everywhere
    mem[2047] = 16'h1807; // LDI 7
    do_reset();
    while (bus.prog_addr !== 11'd2047 && guard < 7000) begin
      @(negedge clk);
      guard++;
    end
    n_tests++;
    if (guard >= 7000) begin
      n_fail++;
      $display("FAIL wrap_timeout: addr=%0d after %0d cycles, required 2047", bus.prog_addr, guard);
    end
    repeat (3) @(negedge clk); // EXECUTE of address 2047
    n_tests++;
    if ({bus.prog_addr, bus.operand, strb} !== {11'd0, 11'd7, 8'hA0}) begin
      n_fail++;
      $display("FAIL wrap_exec: addr=%h operand=%0d strb=%h, required 0 7 a0", bus.prog_addr, bus.operand, strb);
    end
    @(negedge clk);
    n_tests++;
    if ({bus.prog_addr, instr_count} !== {11'd0, 16'd2048}) begin
      n_fail++;
      $display("FAIL wrap_count: addr=%h cnt=%0d, required 0 2048", bus.prog_addr, instr_count);
    end
    $display("[TB] wrap addr=%0d cnt=%0d", bus.prog_addr, instr_count);
  endtask

  initial begin
    clear_mem(16'h0000);
    test_reset();
    test_program();
    test_halt_persist();
    test_illegal();
    test_stall();
    test_async_reset();
    test_wrap();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/bip_fetch_control.md
Name: bip_fetch_control

Overview:
- Instruction-fetch and control unit for the BIP CPU.
- Reads the 2048x16 program memory; owns the PC and drives the memory address.
- Latches each returned instruction word and decodes it into one-cycle datapath control strobes for the accumulator/ALU/data-RAM.
- It is the reader at the other end of the program-memory address/data interface.

Parameters:
- PC_W, 11, program address width (2048 words).
- INSTR_W, 16, instruction width; opcode = [15:11], operand = [10:0].
- CNT_W, 16, width of the retired-instruction counter.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- enable  in  1  1 = advance; 0 = freeze all state and outputs (control strobes forced 0).
- prog_addr  out  PC_W  address to program memory (registered, equals PC).
- prog_data  in  INSTR_W  program memory read data, valid one cycle after prog_addr changes (synchronous memory).
- operand  out  PC_W  IR[10:0]; data-RAM address or immediate.
- wr_acc  out  1  accumulator write strobe.
- sel_a  out  2  accumulator source: 00 = data RAM, 01 = immediate, 10 = ALU.
- sel_b  out  1  ALU second operand: 0 = data RAM, 1 = immediate.
- alu_op  out  1  0 = add, 1 = subtract.
- rd_ram  out  1  data-RAM read strobe.
- wr_ram  out  1  data-RAM write strobe (store accumulator).
- illegal  out  1  one-cycle pulse on an undefined opcode.
- halted  out  1  high once HALT has executed.
- instr_count  out  CNT_W  retired instructions, saturating.

Behaviour:
- Reset (async, rst=0): PC=0, IR=0, state=ISSUE, all strobes 0, sel_a=00, sel_b=0, alu_op=0, halted=0, instr_count=0, prog_addr=0. Reset mid-instruction discards the instruction.
- The memory returns 16'hFFFF while in reset; that word is never latched because state after reset is ISSUE.
- FSM, 3 cycles per instruction when enable=1:
  - ISSUE: prog_addr=PC held; go to DECODE.
  - DECODE: IR <= prog_data; PC <= PC+1 (mod 2048, 2047 wraps to 0); go to EXECUTE.
  - EXECUTE: strobes driven combinationally from IR for exactly this cycle; instr_count++ unless at max. If opcode=HALT go to HALTED, else go to ISSUE.
  - HALTED: terminal; strobes 0, halted=1; leave only via reset.
- Opcodes and strobes asserted in EXECUTE (strobes not listed are 0, sel/alu_op default 0):
  - 00000 HALT: no strobes.
  - 00001 STO: wr_ram.
  - 00010 LD: rd_ram, wr_acc, sel_a=00.
  - 00011 LDI: wr_acc, sel_a=01.
  - 00100 ADD: rd_ram, wr_acc, sel_a=10, sel_b=0, alu_op=0.
  - 00101 ADDI: wr_acc, sel_a=10, sel_b=1, alu_op=0.
  - 00110 SUB: rd_ram, wr_acc, sel_a=10, sel_b=0, alu_op=1.
  - 00111 SUBI: wr_acc, sel_a=10, sel_b=1, alu_op=1.
  - Any other opcode: no strobes, illegal=1 for one cycle, execution continues (NOP, counted as retired).
- operand = IR[10:0] at all times; it is stable from DECODE+1 through EXECUTE.
- enable=0:
  - State, PC, IR and counter hold; strobes and illegal forced 0.
  - If enable drops in DECODE, prog_data must still be valid when enable returns; the memory holds it because prog_addr is unchanged.
  - If enable drops in EXECUTE, the strobes are reissued when enable returns. The instruction executes exactly once in total: its side effects happen on the first enabled EXECUTE cycle only.
- instr_count saturates at 2^CNT_W-1.

Decomposition:
- Shared package bip_pkg:
  - opcode localparams (OP_HALT..OP_SUBI).
  - sel_a encodings (SEL_RAM, SEL_IMM, SEL_ALU).
  - ALU_ADD/ALU_SUB.
  - FSM state encoding.
  - PC_W and INSTR_W defaults.
- Sub-module bip_decoder: purely combinational opcode -> {wr_acc, sel_a, sel_b, alu_op, rd_ram, wr_ram, illegal}.
- bip_fetch_control keeps the FSM, PC, IR, counter and the EXECUTE gating of the decoder outputs.

Test Plan:
- Reset then program LDI 4; STO 1; LDI 2; LD 1; ADD 1; HALT with enable=1 -> prog_addr sequence 0..5. EXECUTE cycles at 3, 6, 9, 12, 15, 18 after reset release. Strobes as listed in Behaviour (LDI: wr_acc, sel_a=01, operand=4; STO: wr_ram, operand=1). halted=1 from cycle 19; instr_count=6.
- Undefined opcode word 16'hF800 at address 0, then HALT -> illegal pulses exactly once in EXECUTE with no other strobes; instr_count=2; halted=1.
- PC wrap: preload so execution reaches address 2047 holding LDI 7 -> next prog_addr=0, no X on the address.
- Stall: enable=0 for 5 cycles during EXECUTE of ADDI 3 -> strobes 0 while stalled; strobes asserted on exactly one enabled cycle afterwards; instr_count increments once.
- Async reset asserted mid-DECODE, not aligned to clk -> all outputs return to reset values immediately; after release, fetch restarts at address 0.
- HALTED persistence: 100 cycles after HALT with enable toggling -> prog_addr and instr_count constant, all strobes 0.
